// File: rtl/store_aligner.sv
// Store-side byte-lane aligner with a small in-order write buffer drained to
// the data memory over req/ack; also flags misaligned stores and load-after-store hazards.
module store_aligner #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stEn,
  input  logic [2:0]  memCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] rtData,
  output logic        full,
  output logic        addrErr,
  input  logic        ldEn,
  input  logic [31:0] ldAddr,
  output logic        rawHazard,
  output logic        pending,
  output logic        memReq,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memBE,
  input  logic        memAck
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [2:0] ST_SB  = 3'b000;
  localparam logic [2:0] ST_SH  = 3'b001;
  localparam logic [2:0] ST_SWL = 3'b010;
  localparam logic [2:0] ST_SW  = 3'b011;
  localparam logic [2:0] ST_SWR = 3'b110;

  logic [29:0]   word_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic        st_valid;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        accept, pop, hit;
  logic [PW-1:0] off;
  logic        unused_ld;

  assign unused_ld = ^ldAddr[1:0];

  always_comb begin
    st_valid = 1'b1;
    st_data  = rtData;
    st_be    = 4'b1111;
    case (memCtrl)
      ST_SB: begin
        st_data = {4{rtData[7:0]}};
        st_be   = 4'b0001 << addr[1:0];
      end
      ST_SH: begin
        st_data = {2{rtData[15:0]}};
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
      end
      ST_SW: st_be = 4'b1111;
      // SWL keeps the high bytes of rt, SWR the low bytes, split at addr[1:0]
      ST_SWL: begin
        case (addr[1:0])
          2'd0: begin st_data = {24'h0, rtData[31:24]}; st_be = 4'b0001; end
          2'd1: begin st_data = {16'h0, rtData[31:16]}; st_be = 4'b0011; end
          2'd2: begin st_data = {8'h0, rtData[31:8]};   st_be = 4'b0111; end
          default: st_be = 4'b1111;
        endcase
      end
      ST_SWR: begin
        case (addr[1:0])
          2'd1: begin st_data = {rtData[23:0], 8'h0};  st_be = 4'b1110; end
          2'd2: begin st_data = {rtData[15:0], 16'h0}; st_be = 4'b1100; end
          2'd3: begin st_data = {rtData[7:0], 24'h0};  st_be = 4'b1000; end
          default: st_be = 4'b1111;
        endcase
      end
      default: st_valid = 1'b0;
    endcase
  end

  assign addrErr = stEn & (((memCtrl == ST_SH) & addr[0]) |
                           ((memCtrl == ST_SW) & (addr[1:0] != 2'b00)));
  assign full    = (count_q == FULL_CNT);
  assign pending = (count_q != '0);
  assign memReq  = pending;
  assign accept  = stEn & st_valid & ~addrErr & ~full;
  assign pop     = pending & memAck;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (accept) tail_d = tail_q + PW'(1);
    if (pop)    head_d = head_q + PW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q[tail_q] <= addr[31:2];
      data_q[tail_q] <= st_data;
      be_q[tail_q]   <= st_be;
    end
  end

  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) && (word_q[i] == ldAddr[31:2])) hit = 1'b1;
    end
  end

  assign rawHazard = ldEn & hit;
  assign memAddr   = {word_q[head_q], 2'b00};
  assign memWData  = data_q[head_q];
  assign memBE     = be_q[head_q];

endmodule

// File: tb/tb_store_aligner.sv
// Bench for store_aligner: directed alignment table, hand-written buffer
// sequences, and randomized traffic against a byte-level queue model.
module tb_store_aligner;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stEn;
  logic [2:0]  memCtrl;
  logic [31:0] addr, rtData, ldAddr;
  logic        full, addrErr, ldEn, rawHazard, pending, memReq, memAck;
  logic [31:0] memAddr, memWData;
  logic [3:0]  memBE;

  store_aligner #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stEn(stEn), .memCtrl(memCtrl), .addr(addr),
    .rtData(rtData), .full(full), .addrErr(addrErr), .ldEn(ldEn),
    .ldAddr(ldAddr), .rawHazard(rawHazard), .pending(pending),
    .memReq(memReq), .memAddr(memAddr), .memWData(memWData),
    .memBE(memBE), .memAck(memAck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] rt;
    logic        err;
    logic        enq;
    logic [3:0]  be;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic chk_data(input string nm, input logic [3:0] be, input logic [31:0] exp);
    chk(nm, memWData & lane_mask(be), exp & lane_mask(be));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stEn = 1'b0; memCtrl = 3'b000; addr = '0; rtData = '0;
    ldEn = 1'b0; ldAddr = '0; memAck = 1'b0;
  endtask

  task automatic add_vec(input logic [2:0] c, input logic [31:0] a, input logic [31:0] rt,
                         input logic err, input logic enq, input logic [3:0] be,
                         input logic [31:0] data);
    vec_t v;
    v.ctrl = c; v.a = a; v.rt = rt; v.err = err; v.enq = enq; v.be = be; v.data = data;
    vecs.push_back(v);
  endtask

  task automatic store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] rt);
    stEn = 1'b1; memCtrl = c; addr = a; rtData = rt;
  endtask

  // Memory-image view: each written byte lane names the rt byte it receives.
  function automatic void model_store(input logic [2:0] c, input logic [31:0] a,
                                      input logic [31:0] rt, output logic ok,
                                      output logic err, output logic [3:0] be,
                                      output logic [31:0] data);
    int o, src, base;
    o = int'(a[1:0]);
    base = (o / 2) * 2;
    ok = (c == 3'd0) || (c == 3'd1) || (c == 3'd2) || (c == 3'd3) || (c == 3'd6);
    err = ((c == 3'd1) && (o % 2 == 1)) || ((c == 3'd3) && (o != 0));
    be = '0;
    data = '0;
    for (int lane = 0; lane < 4; lane++) begin
      src = -1;
      case (c)
        3'd0: if (lane == o) src = 0;
        3'd1: if (lane == base || lane == base + 1) src = lane - base;
        3'd3: src = lane;
        3'd2: if (lane <= o) src = 3 - o + lane;
        3'd6: if (lane >= o) src = lane - o;
        default: src = -1;
      endcase
      if (src >= 0) begin
        be[lane] = 1'b1;
        data[lane*8 +: 8] = rt[src*8 +: 8];
      end
    end
  endfunction

  initial begin
    logic ok, err, acc, pp, haz;
    logic [3:0] ebe;
    logic [31:0] edata;

    idle();
    rst = 1'b1;
    ldEn = 1'b1;
    #1;
    chk("reset_memReq", memReq, 1'b0);
    chk("reset_pending", pending, 1'b0);
    chk("reset_full", full, 1'b0);
    chk("reset_rawHazard", rawHazard, 1'b0);
    tick();
    rst = 1'b0;
    ldEn = 1'b0;
    #1;
    chk("post_reset_memReq", memReq, 1'b0);

    add_vec(3'b000, 32'h100, 32'h11223344, 0, 1, 4'b0001, 32'h00000044);
    add_vec(3'b000, 32'h101, 32'h11223344, 0, 1, 4'b0010, 32'h00004400);
    add_vec(3'b000, 32'h102, 32'h11223344, 0, 1, 4'b0100, 32'h00440000);
    add_vec(3'b000, 32'h103, 32'h11223344, 0, 1, 4'b1000, 32'h44000000);
    add_vec(3'b010, 32'h200, 32'hAABBCCDD, 0, 1, 4'b0001, 32'h000000AA);
    add_vec(3'b010, 32'h201, 32'hAABBCCDD, 0, 1, 4'b0011, 32'h0000AABB);
    add_vec(3'b010, 32'h202, 32'hAABBCCDD, 0, 1, 4'b0111, 32'h00AABBCC);
    add_vec(3'b010, 32'h203, 32'hAABBCCDD, 0, 1, 4'b1111, 32'hAABBCCDD);
    add_vec(3'b110, 32'h200, 32'hAABBCCDD, 0, 1, 4'b1111, 32'hAABBCCDD);
    add_vec(3'b110, 32'h201, 32'hAABBCCDD, 0, 1, 4'b1110, 32'hBBCCDD00);
    add_vec(3'b110, 32'h202, 32'hAABBCCDD, 0, 1, 4'b1100, 32'hCCDD0000);
    add_vec(3'b110, 32'h203, 32'hAABBCCDD, 0, 1, 4'b1000, 32'hDD000000);
    add_vec(3'b001, 32'h300, 32'h11223344, 0, 1, 4'b0011, 32'h00003344);
    add_vec(3'b001, 32'h302, 32'h11223344, 0, 1, 4'b1100, 32'h33440000);
    add_vec(3'b011, 32'h304, 32'hDEADBEEF, 0, 1, 4'b1111, 32'hDEADBEEF);
    add_vec(3'b001, 32'h301, 32'h11223344, 1, 0, 4'b0000, 32'h0);
    add_vec(3'b011, 32'h302, 32'h11223344, 1, 0, 4'b0000, 32'h0);
    add_vec(3'b011, 32'h303, 32'h11223344, 1, 0, 4'b0000, 32'h0);
    add_vec(3'b111, 32'h300, 32'h11223344, 0, 0, 4'b0000, 32'h0);

    foreach (vecs[i]) begin
      idle();
      store(vecs[i].ctrl, vecs[i].a, vecs[i].rt);
      #1;
      chk("tbl_addrErr", addrErr, vecs[i].err);
      tick();
      stEn = 1'b0;
      chk("tbl_pending", pending, vecs[i].enq);
      if (vecs[i].enq) begin
        chk("tbl_memAddr", memAddr, {vecs[i].a[31:2], 2'b00});
        chk("tbl_memBE", memBE, vecs[i].be);
        chk_data("tbl_memWData", vecs[i].be, vecs[i].data);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        chk("tbl_drained", pending, 1'b0);
      end
    end

    // SB stream with ack held high: one write per cycle, no bubbles.
    idle();
    memAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      store(3'b000, 32'h100 + 32'(i), 32'h11223344);
      tick();
      chk("sb_memReq", memReq, 1'b1);
      chk("sb_memAddr", memAddr, 32'h100);
      chk("sb_memBE", memBE, 4'(4'b0001 << i));
      chk_data("sb_memWData", memBE, 32'h44444444);
    end
    stEn = 1'b0;
    tick();
    chk("sb_done", pending, 1'b0);

    // Backpressure
    idle();
    store(3'b011, 32'h500, 32'hA1A1A1A1);
    tick();
    store(3'b011, 32'h504, 32'hB2B2B2B2);
    tick();
    store(3'b011, 32'h508, 32'hC3C3C3C3);
    #1;
    chk("bp_full", full, 1'b1);
    tick();
    stEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_full", full, 1'b1);
      chk("bp_hold_addr", memAddr, 32'h500);
      chk("bp_hold_data", memWData, 32'hA1A1A1A1);
      chk("bp_hold_be", memBE, 4'hF);
      tick();
    end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    chk("bp_after_ack_full", full, 1'b0);
    chk("bp_after_ack_addr", memAddr, 32'h504);
    chk("bp_after_ack_data", memWData, 32'hB2B2B2B2);
    store(3'b011, 32'h50C, 32'hD4D4D4D4);
    memAck = 1'b1;
    tick();
    stEn = 1'b0; memAck = 1'b0;
    chk("bp_acc_pop_pending", pending, 1'b1);
    chk("bp_acc_pop_full", full, 1'b0);
    chk("bp_acc_pop_addr", memAddr, 32'h50C);
    chk("bp_acc_pop_data", memWData, 32'hD4D4D4D4);
    store(3'b011, 32'h510, 32'hE5E5E5E5);
    tick();
    store(3'b011, 32'h514, 32'hF6F6F6F6);
    memAck = 1'b1;
    tick();
    stEn = 1'b0; memAck = 1'b0;
    chk("bp_full_refuse_addr", memAddr, 32'h510);
    chk("bp_full_refuse_full", full, 1'b0);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    chk("bp_full_refuse_empty", pending, 1'b0);

    // Hazard
    idle();
    store(3'b011, 32'h400, 32'h12345678);
    tick();
    stEn = 1'b0;
    ldEn = 1'b1; ldAddr = 32'h403;
    #1;
    chk("haz_same_word", rawHazard, 1'b1);
    ldAddr = 32'h404;
    #1;
    chk("haz_next_word", rawHazard, 1'b0);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    ldAddr = 32'h403;
    #1;
    chk("haz_after_drain", rawHazard, 1'b0);

    // Reset with two entries outstanding
    idle();
    store(3'b011, 32'h700, 32'h01010101);
    tick();
    store(3'b011, 32'h704, 32'h02020202);
    tick();
    stEn = 1'b0;
    chk("rst_pre_full", full, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_memReq", memReq, 1'b0);
    chk("rst_async_pending", pending, 1'b0);
    chk("rst_async_full", full, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    memAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_write", memReq, 1'b0);
    end

    // Randomized traffic against the queue model
    idle();
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      stEn   = 1'($urandom_range(0, 1));
      memCtrl = 3'($urandom_range(0, 7));
      addr   = 32'h600 + 32'($urandom_range(0, 15));
      rtData = $urandom;
      memAck = 1'($urandom_range(0, 1));
      ldEn   = 1'($urandom_range(0, 1));
      ldAddr = 32'h600 + 32'($urandom_range(0, 15));
      #1;
      model_store(memCtrl, addr, rtData, ok, err, ebe, edata);
      haz = 1'b0;
      foreach (q[k]) if (q[k].w == ldAddr[31:2]) haz = 1'b1;
      chk("rnd_addrErr", addrErr, stEn & err);
      chk("rnd_full", full, q.size() == DEPTH);
      chk("rnd_memReq", memReq, q.size() != 0);
      chk("rnd_rawHazard", rawHazard, ldEn & haz);
      if (q.size() != 0) begin
        chk("rnd_memAddr", memAddr, {q[0].w, 2'b00});
        chk("rnd_memBE", memBE, q[0].be);
        chk_data("rnd_memWData", q[0].be, q[0].d);
      end
      acc = stEn & ok & ~err & (q.size() != DEPTH);
      pp  = memAck & (q.size() != 0);
      tick();
      if (pp) void'(q.pop_front());
      if (acc) begin
        ent_t e;
        e.w = addr[31:2]; e.d = edata; e.be = ebe;
        q.push_back(e);
      end
    end
    idle();
    memAck = 1'b1;
    repeat (DEPTH + 1) tick();
    chk("rnd_drained", pending, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
